id_ex_pipe_reg: RTL

Pipeline register between the Decode and Execute stages of the pipelined RISC core. Captures decoded operands, immediates, register addresses and control bits each cycle. Presents them to the Execute stage, including the rs2 operand consumed by the Execute-stage forwarding muxes. Supports stall (hold), flush (bubble insertion) and a saturating bubble counter for performance debug.

---
 rtl/id_ex_pipe_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
// Decode-to-Execute pipeline register with stall, flush/bubble insertion and a
// saturating bubble counter. All outputs come directly from flops.
module id_ex_pipe_reg #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallE,
  input  logic                  FlushE,
  input  logic                  ValidD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] rs1_dataD,
  input  logic [DATA_WIDTH-1:0] rs2_dataD,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic [4:0]            Rs1D,
  input  logic [4:0]            Rs2D,
  input  logic [4:0]            RdD,
  input  logic                  RegWriteD,
  input  logic                  MemWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic [2:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic                  BranchD,
  input  logic                  JumpD,
  output logic                  ValidE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] rs1_dataE,
  output logic [DATA_WIDTH-1:0] rs2_dataE,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E,
  output logic [4:0]            RdE,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            ALUControlE,
  output logic                  ALUSrcE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic [CNT_WIDTH-1:0]  BubbleCount
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic                  reg_write;
    logic                  mem_write;
    logic [1:0]            result_src;
    logic [2:0]            alu_control;
    logic                  alu_src;
    logic                  branch;
    logic                  jump;
  } stage_t;

  stage_t                 dec_in;
  stage_t                 stage_d, stage_q;
  logic [CNT_WIDTH-1:0]   cnt_d, cnt_q;
  logic                   bubble;

  // Gather decode-stage inputs into one record.
  always_comb begin
    dec_in             = '0;
    dec_in.valid       = ValidD;
    dec_in.pc          = PCD;
    dec_in.rs1_data    = rs1_dataD;
    dec_in.rs2_data    = rs2_dataD;
    dec_in.imm_ext     = ImmExtD;
    dec_in.rs1         = Rs1D;
    dec_in.rs2         = Rs2D;
    dec_in.rd          = RdD;
    dec_in.reg_write   = RegWriteD;
    dec_in.mem_write   = MemWriteD;
    dec_in.result_src  = ResultSrcD;
    dec_in.alu_control = ALUControlD;
    dec_in.alu_src     = ALUSrcD;
    dec_in.branch      = BranchD;
    dec_in.jump        = JumpD;
  end

  // Next state: flush beats stall; an unstalled invalid decode is also a bubble.
  always_comb begin
    bubble  = FlushE | (~StallE & ~ValidD);
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (bubble) begin
      stage_d = '0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end else if (!StallE) begin
      stage_d = dec_in;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      cnt_q   <= '0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ValidE      = stage_q.valid;
  assign PCE         = stage_q.pc;
  assign rs1_dataE   = stage_q.rs1_data;
  assign rs2_dataE   = stage_q.rs2_data;
  assign ImmExtE     = stage_q.imm_ext;
  assign Rs1E        = stage_q.rs1;
  assign Rs2E        = stage_q.rs2;
  assign RdE         = stage_q.rd;
  assign RegWriteE   = stage_q.reg_write;
  assign MemWriteE   = stage_q.mem_write;
  assign ResultSrcE  = stage_q.result_src;
  assign ALUControlE = stage_q.alu_control;
  assign ALUSrcE     = stage_q.alu_src;
  assign BranchE     = stage_q.branch;
  assign JumpE       = stage_q.jump;
  assign BubbleCount = cnt_q;

endmodule
